preddr_drain_scheduler: RTL

- Read-side controller that drains the pre-DDR FIFO (64-bit words from the 18-to-64 converter) into bursts for the DDR write port.
- Collects up to BURST_LEN words into a local burst buffer, issues one address/length command, then streams the buffered words.
- Tracks the capture address and enforces a capture-size limit, flushing the FIFO once memory is full.
- Signals end of drain after the converter's capture_done_out.

---
 rtl/preddr_pkg.sv | 19 +
 rtl/preddr_drain_scheduler_if.sv | 23 ++
 rtl/preddr_burst_buffer.sv | 20 ++
 rtl/preddr_drain_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/preddr_pkg.sv
// Shared types and constants for the pre-DDR drain scheduler.
package preddr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t FILL = 3'd1;
  localparam state_t CMD  = 3'd2;
  localparam state_t DATA = 3'd3;
  localparam state_t FULL = 3'd4;

  localparam int unsigned WORD_BYTES = 8;

  // Width able to hold a word count of 0..n inclusive.
  function automatic int unsigned burst_len_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/preddr_drain_scheduler_if.sv
// DDR write-port command and data channels between the scheduler and the DDR controller.
interface preddr_drain_scheduler_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              ddr_wr_req;
  logic              ddr_wr_grant;
  logic [ADDR_W-1:0] ddr_wr_addr;
  logic [4:0]        ddr_wr_len;
  logic [63:0]       ddr_wdata;
  logic              ddr_wdata_valid;
  logic              ddr_wdata_ready;
  logic              ddr_wdata_last;

  modport master (
    output ddr_wr_req, ddr_wr_addr, ddr_wr_len, ddr_wdata, ddr_wdata_valid, ddr_wdata_last,
    input  ddr_wr_grant, ddr_wdata_ready
  );

  modport slave (
    input  ddr_wr_req, ddr_wr_addr, ddr_wr_len, ddr_wdata, ddr_wdata_valid, ddr_wdata_last,
    output ddr_wr_grant, ddr_wdata_ready
  );
endinterface

// File: rtl/preddr_burst_buffer.sv
// Local burst staging buffer: one synchronous write port, one asynchronous read port.
module preddr_burst_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] wptr,
  input  logic [63:0]   din,
  input  logic [PW-1:0] rptr,
  output logic [63:0]   dout
);
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= din;
  end

  assign dout = mem[rptr];
endmodule

// File: rtl/preddr_drain_scheduler.sv
// Drains the pre-DDR FIFO into DDR write bursts, tracking capture address and size limit.
module preddr_drain_scheduler
  import preddr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              enabled,
  input  logic              arm,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_max_words,
  input  logic              fifo_empty,
  input  logic [63:0]       fifo_dout,
  output logic              fifo_rd,
  output logic              fifo_flush,
  input  logic              capture_done_in,
  preddr_drain_scheduler_if.master ddr,
  output logic [CNT_W-1:0]  words_written,
  output logic              mem_full,
  output logic              drain_done,
  output logic              busy
);
  localparam int unsigned CW = burst_len_w(BURST_LEN);
  localparam int unsigned PW = CW - 1;

  state_t            state;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd;
  logic              done_pending;
  logic [4:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       buf_dout;

  logic              under_limit, pop, limit_hit, dp_next, close, last_beat, burst_limit;
  logic [CW-1:0]     cnt_next;
  logic [CNT_W-1:0]  ww_burst;
  logic [ADDR_W-1:0] burst_addr;

  // Close decisions look at the count as it will be after this cycle's pop.
  always_comb begin
    under_limit = (cfg_max_words == '0) || ((words_written + CNT_W'(count)) < cfg_max_words);
    pop         = (state == FILL) && enabled && !fifo_empty &&
                  (count < CW'(BURST_LEN)) && under_limit;
    cnt_next    = count + CW'(pop);
    limit_hit   = (cfg_max_words != '0) && ((words_written + CNT_W'(cnt_next)) >= cfg_max_words);
    dp_next     = done_pending || capture_done_in;
    close       = (cnt_next != '0) &&
                  ((cnt_next == CW'(BURST_LEN)) || limit_hit || (dp_next && fifo_empty));
    last_beat   = (5'(rd) == (len_q - 5'd1));
    ww_burst    = words_written + CNT_W'(len_q);
    burst_limit = (cfg_max_words != '0) && (ww_burst >= cfg_max_words);
    burst_addr  = cfg_base_addr + ADDR_W'(words_written) * ADDR_W'(WORD_BYTES);
  end

  assign fifo_rd             = pop;
  assign fifo_flush          = (state == FULL) && enabled && !fifo_empty;
  assign busy                = (state != IDLE);
  assign ddr.ddr_wr_req      = (state == CMD);
  assign ddr.ddr_wr_addr     = addr_q;
  assign ddr.ddr_wr_len      = len_q;
  assign ddr.ddr_wdata       = buf_dout;
  assign ddr.ddr_wdata_valid = (state == DATA);
  assign ddr.ddr_wdata_last  = (state == DATA) && last_beat;

  preddr_burst_buffer #(
    .DEPTH (BURST_LEN),
    .PW    (PW)
  ) u_buf (
    .clk  (rd_clk),
    .we   (pop),
    .wptr (count[PW-1:0]),
    .din  (fifo_dout),
    .rptr (rd),
    .dout (buf_dout)
  );

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      rd            <= '0;
      done_pending  <= 1'b0;
      len_q         <= '0;
      addr_q        <= '0;
      words_written <= '0;
      mem_full      <= 1'b0;
      drain_done    <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (state != IDLE && capture_done_in) done_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (arm && enabled) begin
            state         <= FILL;
            words_written <= '0;
            mem_full      <= 1'b0;
            done_pending  <= 1'b0;
            count         <= '0;
          end
        end
        FILL: begin
          if (!enabled) begin
            state        <= IDLE;
            count        <= '0;
            done_pending <= 1'b0;
          end else begin
            count <= cnt_next;
            if (close) begin
              addr_q <= burst_addr;
              len_q  <= 5'(cnt_next);
              state  <= CMD;
            end else if (dp_next && fifo_empty) begin
              drain_done   <= 1'b1;
              done_pending <= 1'b0;
              state        <= IDLE;
            end else if (limit_hit) begin
              mem_full <= 1'b1;
              state    <= FULL;
            end
          end
        end
        CMD: begin
          if (ddr.ddr_wr_grant) begin
            rd    <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (ddr.ddr_wdata_ready) begin
            if (last_beat) begin
              words_written <= ww_burst;
              count         <= '0;
              if (burst_limit) mem_full <= 1'b1;
              // A disable seen during the burst is honoured only once it completes.
              if (!enabled) begin
                state        <= IDLE;
                done_pending <= 1'b0;
              end else if (burst_limit) begin
                state <= FULL;
              end else begin
                state <= FILL;
              end
            end else begin
              rd <= rd + PW'(1);
            end
          end
        end
        FULL: begin
          if (!enabled) begin
            state        <= IDLE;
            count        <= '0;
            done_pending <= 1'b0;
          end else if (arm) begin
            state         <= FILL;
            words_written <= '0;
            mem_full      <= 1'b0;
            done_pending  <= 1'b0;
            count         <= '0;
          end else if (dp_next && fifo_empty) begin
            drain_done   <= 1'b1;
            done_pending <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
